// File: rtl/alu_result_fifo_if.sv
// Handshake bundle between the ALU capture side, the result FIFO and its consumer.
// slave is the FIFO's view; master is the ALU/consumer side that drives i_* and observes o_*.
interface alu_result_fifo_if #(
    parameter int M     = 4,
    parameter int DEPTH = 4
);
    localparam int AW = $clog2(DEPTH);

    logic          i_valid;
    logic [M-1:0]  i_result;
    logic [3:0]    i_status;
    logic          i_ready;
    logic          i_clear;

    logic          o_valid;
    logic [M-1:0]  o_result;
    logic [3:0]    o_status;
    logic [AW:0]   o_count;
    logic          o_full;
    logic          o_empty;
    logic          o_overflow;
    logic [7:0]    o_drop_cnt;
    logic [3:0]    o_status_acc;

    modport master (
        output i_valid, i_result, i_status, i_ready, i_clear,
        input  o_valid, o_result, o_status, o_count, o_full, o_empty,
               o_overflow, o_drop_cnt, o_status_acc
    );

    modport slave (
        input  i_valid, i_result, i_status, i_ready, i_clear,
        output o_valid, o_result, o_status, o_count, o_full, o_empty,
               o_overflow, o_drop_cnt, o_status_acc
    );
endinterface

// File: rtl/alu_result_fifo.sv
// First-word-fall-through capture FIFO for ALU result/status pairs. Never back-pressures:
// writes into a full FIFO are dropped and counted; status flags of accepted writes are OR-ed.
module alu_result_fifo #(
    parameter int  M     = 4,
    parameter int  DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic                i_clk,
    input  logic                i_reset,
    alu_result_fifo_if.slave    bus
);
    logic [M+3:0]  mem_q [DEPTH];
    logic [M+3:0]  mem_d [DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          overflow_q, overflow_d;
    logic [7:0]    drop_cnt_q, drop_cnt_d;
    logic [3:0]    status_acc_q, status_acc_d;

    logic full, empty, pop, push, drop;

    assign full  = (count_q == (AW+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign pop   = !empty && bus.i_ready;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign push  = bus.i_valid && (!full || pop);
    assign drop  = bus.i_valid && full && !pop;

    always_comb begin
        mem_d        = mem_q;
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        count_d      = count_q + (AW+1)'(push) - (AW+1)'(pop);
        overflow_d   = bus.i_clear ? 1'b0 : overflow_q;
        drop_cnt_d   = bus.i_clear ? 8'd0 : drop_cnt_q;
        status_acc_d = bus.i_clear ? 4'd0 : status_acc_q;

        if (push) begin
            mem_d[wr_ptr_q] = {bus.i_status, bus.i_result};
            wr_ptr_d        = wr_ptr_q + 1'b1;
            status_acc_d    = status_acc_d | bus.i_status;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        // Same-cycle events are applied on top of a clear, so they win over it.
        if (drop) begin
            overflow_d = 1'b1;
            if (drop_cnt_d != 8'hFF) begin
                drop_cnt_d = drop_cnt_d + 8'd1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            mem_q        <= '{default: '0};
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            overflow_q   <= 1'b0;
            drop_cnt_q   <= '0;
            status_acc_q <= '0;
        end else begin
            mem_q        <= mem_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            overflow_q   <= overflow_d;
            drop_cnt_q   <= drop_cnt_d;
            status_acc_q <= status_acc_d;
        end
    end

    assign bus.o_valid      = !empty;
    assign bus.o_result     = empty ? '0 : mem_q[rd_ptr_q][M-1:0];
    assign bus.o_status     = empty ? '0 : mem_q[rd_ptr_q][M+3:M];
    assign bus.o_count      = count_q;
    assign bus.o_full       = full;
    assign bus.o_empty      = empty;
    assign bus.o_overflow   = overflow_q;
    assign bus.o_drop_cnt   = drop_cnt_q;
    assign bus.o_status_acc = status_acc_q;
endmodule

// File: tb/tb_alu_result_fifo.sv
// Directed bench for alu_result_fifo: fill/drain, overflow, clear priority, full push+pop,
// wrap-around and asynchronous reset, with hand-computed expectations.
module tb_alu_result_fifo;
    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    alu_result_fifo_if #(.M(4), .DEPTH(4)) bus();

    alu_result_fifo #(.M(4), .DEPTH(4)) dut (
        .i_clk   (clk),
        .i_reset (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        bus.i_valid  = 1'b0;
        bus.i_result = '0;
        bus.i_status = '0;
        bus.i_ready  = 1'b0;
        bus.i_clear  = 1'b0;
    endtask

    task automatic test_reset;
        idle_inputs();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
        tests++; if (bus.o_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b exp 0", bus.o_valid); end
        tests++; if (bus.o_empty !== 1'b1) begin fails++; $display("FAIL reset_empty got %b exp 1", bus.o_empty); end
        tests++; if (bus.o_count !== 3'd0) begin fails++; $display("FAIL reset_count got %0d exp 0", bus.o_count); end
        tests++; if (bus.o_drop_cnt !== 8'd0) begin fails++; $display("FAIL reset_drop got %0d exp 0", bus.o_drop_cnt); end
        tests++; if (bus.o_full !== 1'b0) begin fails++; $display("FAIL reset_full got %b exp 0", bus.o_full); end
        tests++; if (bus.o_result !== 4'd0) begin fails++; $display("FAIL reset_result got %h exp 0", bus.o_result); end
    endtask

    task automatic fill_1010;
        logic [3:0] vals [4];
        vals = '{4'd1, 4'd0, 4'd1, 4'd0};
        bus.i_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.i_valid  = 1'b1;
            bus.i_result = vals[i];
            bus.i_status = 4'd0;
            step();
        end
        bus.i_valid = 1'b0;
    endtask

    task automatic test_fill_drain;
        logic [3:0] vals [4];
        vals = '{4'd1, 4'd0, 4'd1, 4'd0};
        // first push into an empty FIFO: visible only after the write edge
        bus.i_valid  = 1'b1;
        bus.i_result = 4'd1;
        tests++; if (bus.o_valid !== 1'b0) begin fails++; $display("FAIL latency_pre got %b exp 0", bus.o_valid); end
        step();
        tests++; if (bus.o_valid !== 1'b1 || bus.o_result !== 4'd1) begin fails++; $display("FAIL latency_post got v=%b r=%h exp v=1 r=1", bus.o_valid, bus.o_result); end
        for (int i = 1; i < 4; i++) begin
            bus.i_result = vals[i];
            step();
        end
        bus.i_valid = 1'b0;
        tests++; if (bus.o_full !== 1'b1) begin fails++; $display("FAIL fill_full got %b exp 1", bus.o_full); end
        tests++; if (bus.o_count !== 3'd4) begin fails++; $display("FAIL fill_count got %0d exp 4", bus.o_count); end
        bus.i_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tests++; if (bus.o_valid !== 1'b1 || bus.o_result !== vals[i]) begin fails++; $display("FAIL drain_%0d got v=%b r=%h exp v=1 r=%h", i, bus.o_valid, bus.o_result, vals[i]); end
            step();
        end
        bus.i_ready = 1'b0;
        tests++; if (bus.o_empty !== 1'b1 || bus.o_result !== 4'd0) begin fails++; $display("FAIL drain_empty got e=%b r=%h exp e=1 r=0", bus.o_empty, bus.o_result); end
    endtask

    task automatic test_overflow;
        fill_1010();
        bus.i_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.i_valid  = 1'b1;
            bus.i_result = 4'd7;
            bus.i_status = 4'hF;
            step();
        end
        idle_inputs();
        tests++; if (bus.o_overflow !== 1'b1) begin fails++; $display("FAIL ovf_flag got %b exp 1", bus.o_overflow); end
        tests++; if (bus.o_drop_cnt !== 8'd3) begin fails++; $display("FAIL ovf_drop got %0d exp 3", bus.o_drop_cnt); end
        tests++; if (bus.o_status_acc !== 4'd0) begin fails++; $display("FAIL ovf_acc got %b exp 0000", bus.o_status_acc); end
        tests++; if (bus.o_count !== 3'd4 || bus.o_result !== 4'd1) begin fails++; $display("FAIL ovf_head got c=%0d r=%h exp c=4 r=1", bus.o_count, bus.o_result); end
        bus.i_clear = 1'b1;
        step();
        bus.i_clear = 1'b0;
        tests++; if (bus.o_overflow !== 1'b0 || bus.o_drop_cnt !== 8'd0) begin fails++; $display("FAIL clear got ovf=%b drop=%0d exp ovf=0 drop=0", bus.o_overflow, bus.o_drop_cnt); end
        tests++; if (bus.o_count !== 3'd4) begin fails++; $display("FAIL clear_count got %0d exp 4", bus.o_count); end
    endtask

    task automatic test_full_push_pop;
        logic [3:0] exp_seq [4];
        exp_seq = '{4'd0, 4'd1, 4'd0, 4'b1011};
        bus.i_valid  = 1'b1;
        bus.i_ready  = 1'b1;
        bus.i_result = 4'b1011;
        bus.i_status = 4'd0;
        step();
        bus.i_valid = 1'b0;
        tests++; if (bus.o_count !== 3'd4) begin fails++; $display("FAIL pp_count got %0d exp 4", bus.o_count); end
        tests++; if (bus.o_drop_cnt !== 8'd0 || bus.o_overflow !== 1'b0) begin fails++; $display("FAIL pp_drop got drop=%0d ovf=%b exp 0/0", bus.o_drop_cnt, bus.o_overflow); end
        for (int i = 0; i < 4; i++) begin
            tests++; if (bus.o_result !== exp_seq[i]) begin fails++; $display("FAIL pp_out_%0d got %h exp %h", i, bus.o_result, exp_seq[i]); end
            step();
        end
        bus.i_ready = 1'b0;
        tests++; if (bus.o_empty !== 1'b1) begin fails++; $display("FAIL pp_empty got %b exp 1", bus.o_empty); end
    endtask

    task automatic test_clear_priority;
        bus.i_valid  = 1'b1;
        bus.i_result = 4'd2;
        bus.i_status = 4'b0001;
        step();
        bus.i_status = 4'b0100;
        bus.i_clear  = 1'b1;
        step();
        bus.i_clear  = 1'b0;
        tests++; if (bus.o_status_acc !== 4'b0100) begin fails++; $display("FAIL clr_push_acc got %b exp 0100", bus.o_status_acc); end
        bus.i_status = 4'd0;
        step();
        step();
        // FIFO full; a drop together with a clear leaves exactly one counted drop
        bus.i_clear = 1'b1;
        step();
        bus.i_clear = 1'b0;
        bus.i_valid = 1'b1;
        step();
        bus.i_clear = 1'b1;
        step();
        idle_inputs();
        tests++; if (bus.o_drop_cnt !== 8'd1 || bus.o_overflow !== 1'b1) begin fails++; $display("FAIL clr_drop got drop=%0d ovf=%b exp 1/1", bus.o_drop_cnt, bus.o_overflow); end
        tests++; if (bus.o_status_acc !== 4'b0000) begin fails++; $display("FAIL clr_drop_acc got %b exp 0000", bus.o_status_acc); end
        bus.i_clear = 1'b1;
        bus.i_ready = 1'b1;
        for (int i = 0; i < 4; i++) step();
        idle_inputs();
        tests++; if (bus.o_empty !== 1'b1 || bus.o_drop_cnt !== 8'd0) begin fails++; $display("FAIL clr_end got e=%b drop=%0d exp 1/0", bus.o_empty, bus.o_drop_cnt); end
    endtask

    task automatic test_wrap;
        bus.i_valid  = 1'b1;
        bus.i_ready  = 1'b1;
        bus.i_result = 4'd0;
        step();
        for (int i = 1; i < 10; i++) begin
            tests++; if (bus.o_result !== 4'(i - 1) || bus.o_count !== 3'd1) begin fails++; $display("FAIL wrap_%0d got r=%h c=%0d exp r=%h c=1", i, bus.o_result, bus.o_count, 4'(i - 1)); end
            bus.i_result = 4'(i);
            step();
        end
        tests++; if (bus.o_result !== 4'd9) begin fails++; $display("FAIL wrap_last got %h exp 9", bus.o_result); end
        bus.i_valid = 1'b0;
        step();
        bus.i_ready = 1'b0;
        tests++; if (bus.o_empty !== 1'b1) begin fails++; $display("FAIL wrap_empty got %b exp 1", bus.o_empty); end
    endtask

    task automatic test_status_reset;
        bus.i_clear = 1'b1;
        step();
        bus.i_clear  = 1'b0;
        bus.i_valid  = 1'b1;
        bus.i_result = 4'd3;
        bus.i_status = 4'b0010;
        step();
        bus.i_result = 4'd5;
        bus.i_status = 4'b1000;
        step();
        idle_inputs();
        tests++; if (bus.o_status_acc !== 4'b1010) begin fails++; $display("FAIL acc got %b exp 1010", bus.o_status_acc); end
        tests++; if (bus.o_count !== 3'd2 || bus.o_status !== 4'b0010) begin fails++; $display("FAIL acc_head got c=%0d s=%b exp c=2 s=0010", bus.o_count, bus.o_status); end
        #2;
        rst_n = 1'b0;
        #1;
        tests++; if (bus.o_valid !== 1'b0 || bus.o_empty !== 1'b1 || bus.o_full !== 1'b0) begin fails++; $display("FAIL async_flags got v=%b e=%b f=%b exp 0/1/0", bus.o_valid, bus.o_empty, bus.o_full); end
        tests++; if (bus.o_count !== 3'd0 || bus.o_result !== 4'd0 || bus.o_status !== 4'd0) begin fails++; $display("FAIL async_data got c=%0d r=%h s=%b exp 0/0/0", bus.o_count, bus.o_result, bus.o_status); end
        tests++; if (bus.o_status_acc !== 4'd0 || bus.o_overflow !== 1'b0 || bus.o_drop_cnt !== 8'd0) begin fails++; $display("FAIL async_sticky got acc=%b ovf=%b drop=%0d exp 0/0/0", bus.o_status_acc, bus.o_overflow, bus.o_drop_cnt); end
        step();
        rst_n = 1'b1;
        step();
        tests++; if (bus.o_empty !== 1'b1) begin fails++; $display("FAIL post_reset_empty got %b exp 1", bus.o_empty); end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        test_reset();
        test_fill_drain();
        test_overflow();
        test_full_push_pop();
        test_clear_priority();
        test_wrap();
        test_status_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
